// File: rtl/ethernet_mmio_adapter_if.sv
// SoC request/response stream plus the ethernet controller register port, seen by the adapter.
interface ethernet_mmio_adapter_if #(
   parameter int data_width_p = 32,
   parameter int addr_width_p = 40
);
   localparam int size_width_lp = $clog2($clog2(data_width_p/8) + 1);

   logic                     req_v_i;
   logic                     req_ready_and_o;
   logic                     req_w_i;
   logic [addr_width_p-1:0]  req_addr_i;
   logic [size_width_lp-1:0] req_size_i;
   logic [data_width_p-1:0]  req_data_i;

   logic                     resp_v_o;
   logic                     resp_ready_and_i;
   logic                     resp_w_o;
   logic                     resp_err_o;
   logic [data_width_p-1:0]  resp_data_o;

   logic [13:0]              addr_o;
   logic                     write_en_o;
   logic                     read_en_o;
   logic [size_width_lp-1:0] op_size_o;
   logic [data_width_p-1:0]  write_data_o;
   logic [data_width_p-1:0]  read_data_i;

   modport slave (
      input  req_v_i, req_w_i, req_addr_i, req_size_i, req_data_i, resp_ready_and_i, read_data_i,
      output req_ready_and_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o,
             addr_o, write_en_o, read_en_o, op_size_o, write_data_o
   );

   modport master (
      output req_v_i, req_w_i, req_addr_i, req_size_i, req_data_i, resp_ready_and_i, read_data_i,
      input  req_ready_and_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o,
             addr_o, write_en_o, read_en_o, op_size_o, write_data_o
   );
endinterface

// File: rtl/ethernet_mmio_adapter.sv
// Serialises SoC MMIO requests onto the ethernet controller's single-cycle register port,
// one access outstanding, with window/alignment decode and size-masked buffered responses.
module ethernet_mmio_adapter #(
   parameter int                     data_width_p = 32,
   parameter int                     addr_width_p = 40,
   parameter logic [addr_width_p-1:0] base_addr_p = '0
) (
   input logic                    clk_i,
   input logic                    reset_i,
   ethernet_mmio_adapter_if.slave bus
);
   localparam int size_width_lp = $clog2($clog2(data_width_p/8) + 1);
   localparam int bytes_lp      = data_width_p/8;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

   state_e                   state, state_next;
   logic                     w_r, err_r;
   logic [13:0]              addr_r;
   logic [size_width_lp-1:0] size_r;
   logic [data_width_p-1:0]  wdata_r, rdata_r;
   logic                     handshake, req_err;

   function automatic logic decode_err(input logic [addr_width_p-1:0]  addr,
                                       input logic [size_width_lp-1:0] size);
      logic [addr_width_p-1:0] align_mask;
      logic                    bad_window, bad_size, bad_align;
      bad_window = addr[addr_width_p-1:14] != base_addr_p[addr_width_p-1:14];
      bad_size   = 32'(size) > 32'($clog2(bytes_lp));
      align_mask = (addr_width_p'(1) << size) - addr_width_p'(1);
      bad_align  = |(addr & align_mask);
      return bad_window | bad_size | bad_align;
   endfunction

   // Keeps the low 8<<size bits; size is already known not to exceed the port width.
   function automatic logic [data_width_p-1:0] size_mask(input logic [size_width_lp-1:0] size);
      logic [data_width_p-1:0] m;
      m = '0;
      for (int b = 0; b < bytes_lp; b++)
         if (b < (1 << size)) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   assign handshake = bus.req_v_i & bus.req_ready_and_o;
   assign req_err   = decode_err(bus.req_addr_i, bus.req_size_i);

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next          = state;
      bus.req_ready_and_o = 1'b0;
      bus.write_en_o      = 1'b0;
      bus.read_en_o       = 1'b0;
      bus.resp_v_o        = 1'b0;
      unique case (state)
         IDLE: begin
            bus.req_ready_and_o = 1'b1;
            if (bus.req_v_i) state_next = req_err ? RESP : ISSUE;
         end
         ISSUE: begin
            bus.write_en_o = w_r;
            bus.read_en_o  = ~w_r;
            state_next     = w_r ? RESP : CAPTURE;
         end
         CAPTURE: state_next = RESP;
         RESP: begin
            bus.resp_v_o = 1'b1;
            if (bus.resp_ready_and_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Device-side fields only move on accepted, decodable requests so they hold while idle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         w_r     <= 1'b0;
         err_r   <= 1'b0;
         addr_r  <= '0;
         size_r  <= '0;
         wdata_r <= '0;
         rdata_r <= '0;
      end else begin
         if (handshake) begin
            w_r     <= bus.req_w_i;
            err_r   <= req_err;
            rdata_r <= '0;
            if (!req_err) begin
               addr_r  <= bus.req_addr_i[13:0];
               size_r  <= bus.req_size_i;
               wdata_r <= bus.req_data_i;
            end
         end
         if (state == CAPTURE) rdata_r <= bus.read_data_i & size_mask(size_r);
      end
   end

   assign bus.resp_w_o     = w_r;
   assign bus.resp_err_o   = err_r;
   assign bus.resp_data_o  = rdata_r;
   assign bus.addr_o       = addr_r;
   assign bus.op_size_o    = size_r;
   assign bus.write_data_o = wdata_r;
endmodule
